// File: rtl/cic_decim_sequencer_pkg.sv
// Shared types and defaults for the CIC decimator sequencer and its strobe counter.
// Holds the state encoding, default parameter values and the gain-shift helper.
package cic_decim_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } seq_state_t;

    localparam int DEF_PW        = 12;
    localparam int DEF_PERIOD    = 47;
    localparam int DEF_FLUSH_LEN = 2;
    localparam int DEF_SETTLE_N  = 2;
    localparam int GAIN_W        = 6;

    // Two integrator stages each grow the word by log2(period) bits.
    function automatic logic [GAIN_W-1:0] gain_shift_of(input logic [31:0] period);
        logic [31:0] v;
        logic [5:0]  len;
        v   = period - 32'd1;
        len = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) len = 6'(i + 1);
        end
        return GAIN_W'(2 * len);
    endfunction

endpackage

// File: rtl/cic_decim_sequencer_strobe_counter.sv
// Reloadable down-counter issuing a strobe every (period_m1_i + 1) cycles while run_i is high.
// Strobe is combinational from the count register; load_i takes priority over run_i.
module decim_strobe_counter #(
    parameter int PW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          run_i,
    input  logic [PW-1:0] period_m1_i,
    output logic          strobe_o
);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = period_m1_i;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? period_m1_i : cnt_q - 1'b1;
        end
    end

    assign strobe_o = run_i && !load_i && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cic_decim_sequencer.sv
// Sequencer for the shared double-integrator CIC decimator: integrator reset, comb strobe,
// start-up discard and gain shift. All outputs registered; one cycle behind the state they decode.
module cic_decim_sequencer
    import cic_decim_sequencer_pkg::*;
#(
    parameter int pw         = DEF_PW,
    parameter int def_period = DEF_PERIOD,
    parameter int flush_len  = DEF_FLUSH_LEN,
    parameter int settle_n   = DEF_SETTLE_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              cfg_stb_i,
    input  logic [pw-1:0]     cfg_period_i,
    output logic              integ_reset_o,
    output logic              sample_stb_o,
    output logic              out_valid_o,
    output logic [GAIN_W-1:0] gain_shift_o,
    output logic              cfg_err_o,
    output logic              running_o
);

    localparam logic [3:0] FLUSH_INIT  = 4'(flush_len);
    localparam logic [3:0] SETTLE_INIT = 4'(settle_n);

    seq_state_t        state_q, state_d;
    logic [3:0]        flush_cnt_q, flush_cnt_d;
    logic [3:0]        settle_cnt_q, settle_cnt_d;
    logic [pw-1:0]     period_q, period_d;
    logic [GAIN_W-1:0] gain_shift_q, gain_shift_d;
    logic              integ_reset_q, sample_stb_q, out_valid_q, cfg_err_q, running_q;
    logic              cfg_clamp, abort, dec_load, dec_run, dec_strobe;

    assign cfg_clamp = cfg_period_i < pw'(2);
    // Disable or a live reconfiguration kills the current run, including a strobe due this cycle.
    assign abort     = !enable_i || (cfg_stb_i && state_q != IDLE);
    assign dec_load  = (state_q == FLUSH) && (flush_cnt_q <= 4'd1) && !abort;
    assign dec_run   = (state_q == SETTLE || state_q == RUN) && !abort;

    decim_strobe_counter #(.PW(pw)) u_strobe_counter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (dec_load),
        .run_i       (dec_run),
        .period_m1_i (period_q - 1'b1),
        .strobe_o    (dec_strobe)
    );

    always_comb begin
        period_d     = period_q;
        gain_shift_d = gain_shift_q;
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        settle_cnt_d = settle_cnt_q;
        if (cfg_stb_i) begin
            period_d     = cfg_clamp ? pw'(2) : cfg_period_i;
            gain_shift_d = gain_shift_of(32'(period_d));
        end
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end
            end
            FLUSH: begin
                if (flush_cnt_q <= 4'd1) begin
                    state_d      = (settle_n == 0) ? RUN : SETTLE;
                    settle_cnt_d = SETTLE_INIT;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            SETTLE: begin
                if (dec_strobe) begin
                    if (settle_cnt_q <= 4'd1) state_d = RUN;
                    else                      settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            default: ;
        endcase
        if (!enable_i) begin
            state_d = IDLE;
        end else if (cfg_stb_i && state_q != IDLE) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            flush_cnt_q   <= '0;
            settle_cnt_q  <= '0;
            period_q      <= pw'(def_period);
            gain_shift_q  <= gain_shift_of(32'(def_period));
            integ_reset_q <= 1'b1;
            sample_stb_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            cfg_err_q     <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            period_q      <= period_d;
            gain_shift_q  <= gain_shift_d;
            integ_reset_q <= (state_q == IDLE) || (state_q == FLUSH);
            sample_stb_q  <= dec_strobe;
            out_valid_q   <= dec_strobe && (state_q == RUN);
            cfg_err_q     <= cfg_stb_i && cfg_clamp;
            running_q     <= (state_q == RUN);
        end
    end

    assign integ_reset_o = integ_reset_q;
    assign sample_stb_o  = sample_stb_q;
    assign out_valid_o   = out_valid_q;
    assign gain_shift_o  = gain_shift_q;
    assign cfg_err_o     = cfg_err_q;
    assign running_o     = running_q;

endmodule

// File: tb/tb_cic_decim_sequencer.sv
// Scoreboard bench for cic_decim_sequencer: a timeline model predicts strobes and status,
// a negedge monitor pops and compares.
module tb_cic_decim_sequencer;

    localparam int FL = 2;
    localparam int SN = 2;

    typedef struct {
        int cyc;
        bit vld;
    } stb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_stb;
    logic [11:0] cfg_period;
    logic        integ_reset_o, sample_stb_o, out_valid_o, cfg_err_o, running_o;
    logic [5:0]  gain_shift_o;

    int checks = 0;
    int errors = 0;

    stb_t       sq[$];
    logic [9:0] st_q[$];

    int cyc = -1;
    bit m_idle = 1'b1;
    int t0 = 0, mp = 47, per = 47, gain = 12;
    bit prev_integ = 1'b1, prev_run = 1'b0;

    always #5 clk = ~clk;

    cic_decim_sequencer #(
        .pw(12), .def_period(47), .flush_len(FL), .settle_n(SN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable),
        .cfg_stb_i     (cfg_stb),
        .cfg_period_i  (cfg_period),
        .integ_reset_o (integ_reset_o),
        .sample_stb_o  (sample_stb_o),
        .out_valid_o   (out_valid_o),
        .gain_shift_o  (gain_shift_o),
        .cfg_err_o     (cfg_err_o),
        .running_o     (running_o)
    );

    function automatic int ceil_log2(input int x);
        int r;
        r = 0;
        while ((1 << r) < x) r++;
        return r;
    endfunction

    // Timeline model: a run started at edge t0 with period mp flushes for FL cycles,
    // strobes at t0+FL+k*mp (k>=1), and only strobes beyond the SN-th are valid.
    always @(posedge clk) begin
        bit abort, stb, vld, err, ei, er;
        int first, idx;
        cyc++;
        stb = 0; vld = 0; err = 0;
        if (reset) begin
            per = 47; gain = 12; m_idle = 1'b1;
            ei = 1'b1; er = 1'b0;
        end else begin
            ei = prev_integ; er = prev_run;
            abort = !enable || (cfg_stb && !m_idle);
            if (!m_idle && !abort) begin
                first = t0 + FL + mp;
                if (cyc >= first && (cyc - first) % mp == 0) begin
                    stb = 1'b1;
                    idx = (cyc - first) / mp + 1;
                    vld = idx > SN;
                end
            end
            if (cfg_stb) begin
                err  = int'(cfg_period) < 2;
                per  = (int'(cfg_period) < 2) ? 2 : int'(cfg_period);
                gain = 2 * ceil_log2(per);
            end
            if (!enable) begin
                m_idle = 1'b1;
            end else if (m_idle || cfg_stb) begin
                m_idle = 1'b0; t0 = cyc; mp = per;
            end
        end
        prev_integ = m_idle || (cyc - t0 < FL);
        prev_run   = !m_idle && (cyc >= t0 + FL + SN * mp);
        st_q.push_back({ei, er, err, vld, 6'(gain)});
        if (stb) sq.push_back('{cyc, vld});
    end

    always @(negedge clk) begin
        logic [9:0] exp_s, got_s;
        stb_t e;
        if (st_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL status_queue cyc=%0d got=empty exp=entry", cyc);
        end else begin
            exp_s = st_q.pop_front();
            got_s = {integ_reset_o, running_o, cfg_err_o, out_valid_o, gain_shift_o};
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL status cyc=%0d got{integ,run,err,vld,gain}=%b exp=%b", cyc, got_s, exp_s);
            end
        end
        if (sample_stb_o) begin
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL strobe_spurious cyc=%0d got=1 exp=0", cyc);
            end else begin
                e = sq.pop_front();
                if (e.cyc != cyc || e.vld != out_valid_o) begin
                    errors++;
                    $display("FAIL strobe cyc=%0d got_vld=%0d exp_cyc=%0d exp_vld=%0d", cyc, out_valid_o, e.cyc, e.vld);
                end
            end
        end else begin
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                checks++; errors++;
                $display("FAIL strobe_missing cyc=%0d got=0 exp_cyc=%0d", cyc, sq[0].cyc);
                void'(sq.pop_front());
            end
        end
    end

    task automatic step(input bit en, input bit cs, input int cp);
        @(negedge clk);
        enable     = en;
        cfg_stb    = cs;
        cfg_period = 12'(cp);
    endtask

    task automatic wait_stb();
        int k;
        k = 0;
        do begin
            step(1, 0, 0);
            k++;
        end while (!sample_stb_o && k < 300);
        if (!sample_stb_o) begin
            checks++; errors++;
            $display("FAIL wait_stb cyc=%0d got=no_strobe exp=strobe_within_300", cyc);
        end
    endtask

    initial begin
        int cp;
        reset = 1'b1; enable = 1'b0; cfg_stb = 1'b0; cfg_period = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0);
        step(0, 1, 4);                       // latch only while idle
        repeat (26) step(1, 0, 0);
        step(1, 1, 47);                      // live reconfiguration
        repeat (240) step(1, 0, 0);
        step(1, 1, 1);  repeat (20) step(1, 0, 0);
        step(1, 1, 0);  repeat (20) step(1, 0, 0);
        step(1, 1, 5);  repeat (6) step(1, 0, 0);
        repeat (4) step(0, 0, 0);            // drop mid-settle
        repeat (40) step(1, 0, 0);
        repeat (4) step(0, 0, 0);            // drop mid-run
        repeat (30) step(1, 0, 0);
        step(1, 1, 4);
        wait_stb();
        repeat (2) step(1, 0, 0);
        step(1, 1, 6);                       // lands on a strobe-due cycle
        repeat (30) step(1, 0, 0);
        wait_stb();
        repeat (4) step(1, 0, 0);
        step(0, 1, 3);                       // reconfigure as enable falls
        repeat (3) step(0, 0, 0);
        repeat (25) step(1, 0, 0);
        step(1, 1, 9);
        repeat (40) step(1, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step(1, 0, 0); step(1, 0, 0);
        reset = 1'b0;
        repeat (60) step(1, 0, 0);
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       cp = $urandom_range(0, 3);
                1:       cp = $urandom_range(4, 9);
                default: cp = $urandom_range(2, 40);
            endcase
            step($urandom_range(0, 24) != 0, $urandom_range(0, 29) == 0, cp);
        end
        repeat (6) step(0, 0, 0);
        #1;
        checks++;
        if (sq.size() != 0) begin
            errors++;
            $display("FAIL strobe_drain got=%0d_pending exp=0", sq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
